// File: rtl/ps2_mouse_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_mouse_ctrl
//
// Host-side PS/2 mouse controller. After reset it sends the enable-reporting
// command through the transmitter stage and waits for the mouse acknowledge,
// retrying on a bad response or a timeout. Once acknowledged it assembles the
// 3-byte movement packets into signed X/Y deltas, button states and overflow
// flags, and pulses m_done_tick for one cycle per complete packet.
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   tx_idle         transmitter can accept a byte
//   tx_done_tick    transmitter finished sending a byte (pulse)
//   wr_ps2          one-cycle strobe: transmit tx_data
//   tx_data         byte to transmit (the init command)
//   rx_done_tick    receiver byte-valid pulse, rx_data valid with it
//   rx_en           receiver enable
//   xm, ym          signed 9-bit X/Y deltas
//   btnm            buttons {middle, right, left}
//   ovf             overflow flags {y_ov, x_ov}
//   m_done_tick     packet outputs updated this cycle (pulse)
//   init_done       acknowledge received, packet reception active
//   err             sticky: every command attempt failed
// -----------------------------------------------------------------------------
module ps2_mouse_ctrl #(
    parameter logic [7:0] INIT_CMD  = 8'hF4,
    parameter logic [7:0] ACK_BYTE  = 8'hFA,
    parameter int         TO_CYCLES = 2_000_000,
    parameter int         CNT_W     = 21,
    parameter int         MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_idle,
    input  logic       tx_done_tick,
    output logic       wr_ps2,
    output logic [7:0] tx_data,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic [8:0] xm,
    output logic [8:0] ym,
    output logic [2:0] btnm,
    output logic [1:0] ovf,
    output logic       m_done_tick,
    output logic       init_done,
    output logic       err
);

    localparam int AW = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_SEND,
        ST_WTX,
        ST_WACK,
        ST_P1,
        ST_P2,
        ST_P3,
        ST_FAIL
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    attempts_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    // Byte 1 without bit 3 (always 1 in a valid header): {y_ov, x_ov, ys, xs, btn[2:0]}
    logic [6:0]       b1_q;
    logic [7:0]       b2_q;
    logic             wr_ps2_q;
    logic [7:0]       tx_data_q;
    logic             rx_en_q;
    logic [8:0]       xm_q;
    logic [8:0]       ym_q;
    logic [2:0]       btnm_q;
    logic [1:0]       ovf_q;
    logic             m_done_q;
    logic             init_done_q;
    logic             err_q;

    logic cnt_clr;
    logic cnt_run;
    logic to_hit;

    // Shared timeout counter: restarted whenever a new wait begins (entering
    // WACK, P2 or P3), counting only while waiting, saturating at all-ones.
    always_comb begin
        cnt_clr = ((state_q == ST_WTX) && tx_done_tick)
               || ((state_q == ST_P1) && rx_done_tick && rx_data[3])
               || ((state_q == ST_P2) && rx_done_tick);
        cnt_run = (state_q == ST_WACK) || (state_q == ST_P2) || (state_q == ST_P3);
        cnt_d   = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_run && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        to_hit = (cnt_q == TO_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SEND;
            attempts_q  <= '0;
            cnt_q       <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            wr_ps2_q    <= 1'b0;
            tx_data_q   <= INIT_CMD;
            rx_en_q     <= 1'b0;
            xm_q        <= '0;
            ym_q        <= '0;
            btnm_q      <= '0;
            ovf_q       <= '0;
            m_done_q    <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ps2_q <= 1'b0;
            m_done_q <= 1'b0;
            case (state_q)
                ST_SEND: begin
                    if (tx_idle) begin
                        wr_ps2_q   <= 1'b1;
                        tx_data_q  <= INIT_CMD;
                        attempts_q <= attempts_q + 1'b1;
                        state_q    <= ST_WTX;
                    end
                end
                ST_WTX: begin
                    if (tx_done_tick) begin
                        rx_en_q <= 1'b1;
                        state_q <= ST_WACK;
                    end
                end
                ST_WACK: begin
                    // A byte in the timeout cycle is evaluated as a response.
                    if (rx_done_tick && (rx_data == ACK_BYTE)) begin
                        init_done_q <= 1'b1;
                        state_q     <= ST_P1;
                    end else if (rx_done_tick || to_hit) begin
                        rx_en_q <= 1'b0;
                        if (attempts_q < AW'(MAX_RETRY)) begin
                            state_q <= ST_SEND;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_FAIL;
                        end
                    end
                end
                ST_P1: begin
                    // Bytes without the always-one header bit are dropped to resync.
                    if (rx_done_tick && rx_data[3]) begin
                        b1_q    <= {rx_data[7:4], rx_data[2:0]};
                        state_q <= ST_P2;
                    end
                end
                ST_P2: begin
                    if (rx_done_tick) begin
                        b2_q    <= rx_data;
                        state_q <= ST_P3;
                    end else if (to_hit) begin
                        state_q <= ST_P1;
                    end
                end
                ST_P3: begin
                    if (rx_done_tick) begin
                        xm_q     <= {b1_q[3], b2_q};
                        ym_q     <= {b1_q[4], rx_data};
                        btnm_q   <= b1_q[2:0];
                        ovf_q    <= b1_q[6:5];
                        m_done_q <= 1'b1;
                        state_q  <= ST_P1;
                    end else if (to_hit) begin
                        state_q <= ST_P1;
                    end
                end
                ST_FAIL: begin
                    err_q   <= 1'b1;
                    rx_en_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_SEND;
                end
            endcase
        end
    end

    assign wr_ps2      = wr_ps2_q;
    assign tx_data     = tx_data_q;
    assign rx_en       = rx_en_q;
    assign xm          = xm_q;
    assign ym          = ym_q;
    assign btnm        = btnm_q;
    assign ovf         = ovf_q;
    assign m_done_tick = m_done_q;
    assign init_done   = init_done_q;
    assign err         = err_q;

endmodule
